// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller: counts idle cycles, handshakes a sleep
// request with the gated domain, drives the ICG enable and sequences wake-up.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic activity,
    input  logic wake_req,
    input  logic sleep_ack,
    input  logic force_on,
    output logic gate_en,
    output logic sleep_req,
    output logic clk_ready,
    output logic gated
);

    typedef enum logic [2:0] {
        S_RUN,
        S_IDLE_WAIT,
        S_SLEEP_REQ,
        S_GATED,
        S_WAKE
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             idle_now;
    logic             wake_evt;

    // wake_req deliberately does not break an idle run; only activity/force_on do.
    assign idle_now = !activity && !force_on;
    assign wake_evt = wake_req || activity || force_on;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_RUN;
            cnt_reg   <= '0;
            gate_en   <= 1'b1;
            clk_ready <= 1'b1;
            sleep_req <= 1'b0;
            gated     <= 1'b0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (idle_now) begin
                        if (IDLE_CYCLES == 1) begin
                            state_reg <= S_SLEEP_REQ;
                            sleep_req <= 1'b1;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= S_IDLE_WAIT;
                            cnt_reg   <= CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end

                S_IDLE_WAIT: begin
                    if (!idle_now) begin
                        state_reg <= S_RUN;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == IDLE_LAST) begin
                        state_reg <= S_SLEEP_REQ;
                        sleep_req <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_SLEEP_REQ: begin
                    // Abort wins over a same-cycle acknowledge.
                    if (wake_evt) begin
                        state_reg <= S_RUN;
                        sleep_req <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (sleep_ack) begin
                        state_reg <= S_GATED;
                        sleep_req <= 1'b0;
                        gate_en   <= 1'b0;
                        clk_ready <= 1'b0;
                        gated     <= 1'b1;
                    end
                end

                S_GATED: begin
                    if (wake_evt) begin
                        state_reg <= S_WAKE;
                        gate_en   <= 1'b1;
                        gated     <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end

                S_WAKE: begin
                    if (cnt_reg == WAKE_LAST) begin
                        state_reg <= S_RUN;
                        clk_ready <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg <= S_RUN;
                    cnt_reg   <= '0;
                    gate_en   <= 1'b1;
                    clk_ready <= 1'b1;
                    sleep_req <= 1'b0;
                    gated     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: stimulus pushes model predictions into a
// queue, a monitor pops and compares after every clock edge.
module tb_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 2;
    localparam int CNT_W       = 8;

    logic CLK = 1'b0;
    logic RST;
    logic activity, wake_req, sleep_ack, force_on;
    logic gate_en, sleep_req, clk_ready, gated;

    clk_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .activity (activity),
        .wake_req (wake_req),
        .sleep_ack(sleep_ack),
        .force_on (force_on),
        .gate_en  (gate_en),
        .sleep_req(sleep_req),
        .clk_ready(clk_ready),
        .gated    (gated)
    );

    always #5 CLK = ~CLK;

    // Expected outputs packed as {gate_en, sleep_req, clk_ready, gated}
    logic [3:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int cycle_no    = 0;
    bit stim_done   = 0;

    // Behavioural model: what the gated domain sees, not how the FSM encodes it.
    bit m_asleep     = 0;
    bit m_requesting = 0;
    int m_wake_left  = 0;
    int m_idle_run   = 0;

    task automatic model_step(input logic r, input logic a, input logic w,
                              input logic k, input logic f);
        if (r) begin
            m_asleep = 0; m_requesting = 0; m_wake_left = 0; m_idle_run = 0;
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_asleep) begin
            if (w || a || f) begin
                m_asleep    = 0;
                m_wake_left = WAKE_CYCLES;
                m_idle_run  = 0;
            end
        end else if (m_requesting) begin
            if (a || w || f) begin
                m_requesting = 0; m_idle_run = 0;
            end else if (k) begin
                m_requesting = 0; m_asleep = 1; m_idle_run = 0;
            end
        end else begin
            if (a || f) m_idle_run = 0;
            else        m_idle_run++;
            if (m_idle_run >= IDLE_CYCLES) begin
                m_requesting = 1;
                m_idle_run   = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic w,
                         input logic k, input logic f);
        logic [3:0] e;
        RST = r; activity = a; wake_req = w; sleep_ack = k; force_on = f;
        model_step(r, a, w, k, f);
        e = {!m_asleep, m_requesting, (!m_asleep && m_wake_left == 0), m_asleep};
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic busy(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor
    initial begin
        logic [3:0] e;
        logic [3:0] got;
        forever begin
            @(posedge CLK);
            #1;
            cycle_no++;
            got = {gate_en, sleep_req, clk_ready, gated};
            if (exp_q.size() == 0) begin
                if (!stim_done) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_underflow cycle %0d: no expectation queued", cycle_no);
                end
            end else begin
                e = exp_q.pop_front();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got {gate_en,sleep_req,clk_ready,gated}=%b, want %b",
                             cycle_no, got, e);
                end else begin
                    $display("cycle %0d: RST=%b act=%b wake=%b ack=%b force=%b -> %b ok",
                             cycle_no, RST, activity, wake_req, sleep_ack, force_on, got);
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset for two cycles with random inputs
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // Idle entry: sleep_req after edge 16, ack at cycle 20
        idle(20);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        // Stray ack while gated is ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Wake pulse, then watch settle
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        busy(3);

        // Idle break at idle cycle 10, then a full fresh run
        idle(10);
        busy(1);
        idle(15);
        busy(1);
        idle(17);
        // Abort race: ack and activity together
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        busy(2);

        // wake_req during idle run does not break it
        idle(5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(12);
        // wake_req aborts the request
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // force_on in IDLE_WAIT
        idle(8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(16);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        // force_on in GATED, held through WAKE
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while gated
        idle(16);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomised phase, biased so idle runs and handshakes actually happen
        for (int i = 0; i < 4000; i++) begin
            logic r, a, w, k, f;
            r = ($urandom_range(0, 799) == 0);
            a = ($urandom_range(0, 24) == 0);
            w = ($urandom_range(0, 39) == 0);
            k = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 59) == 0);
            drive(r, a, w, k, f);
        end

        stim_done = 1;
        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
